// File: rtl/onchip_mem_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | onchip_mem_seq_pkg : shared constants and state encoding for the RAM
// | fill/verify sequencer.  Revision 1.0
// +----------------------------------------------------------------------------
package onchip_mem_seq_pkg;

  localparam int ADDR_W_DEF      = 15;
  localparam int DATA_W_DEF      = 32;
  localparam int MAX_PENDING_DEF = 4;

  localparam logic OP_FILL   = 1'b0;
  localparam logic OP_VERIFY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage : onchip_mem_seq_pkg
`default_nettype wire

// File: rtl/onchip_mem_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | onchip_mem_seq_if : command/status and Avalon-MM bundle of the sequencer.
// | Revision 1.0
// +----------------------------------------------------------------------------
interface onchip_mem_seq_if
  import onchip_mem_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_op;
  logic [ADDR_W-1:0]   cmd_base;
  logic [ADDR_W:0]     cmd_len;
  logic [DATA_W-1:0]   cmd_pattern;
  logic                busy;
  logic                done;
  logic [ADDR_W:0]     err_count;
  logic [ADDR_W-1:0]   err_first_addr;
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic                avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_pattern,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output cmd_ready, busy, done, err_count, err_first_addr,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_pattern,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  cmd_ready, busy, done, err_count, err_first_addr,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

endinterface : onchip_mem_seq_if
`default_nettype wire

// File: rtl/onchip_mem_seq_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | onchip_mem_seq_pattern : word index counter producing base+i and pattern+i.
// | Revision 1.0
// +----------------------------------------------------------------------------
module onchip_mem_seq_pattern
  import onchip_mem_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [DATA_W-1:0] pattern_in,
  output logic [ADDR_W:0]   idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic [ADDR_W:0]   idx_q, idx_d;

  always_comb begin
    base_d    = base_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    if (load) begin
      base_d    = base_in;
      pattern_d = pattern_in;
      idx_d     = '0;
    end else if (adv) begin
      idx_d = idx_q + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      pattern_q <= '0;
      idx_q     <= '0;
    end else begin
      base_q    <= base_d;
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
    end
  end

  // Both sums wrap naturally at their own widths.
  assign idx  = idx_q;
  assign addr = base_q + idx_q[ADDR_W-1:0];
  assign data = pattern_q + DATA_W'(idx_q);

endmodule : onchip_mem_seq_pattern
`default_nettype wire

// File: rtl/onchip_mem_seq_master.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | onchip_mem_seq_master : Avalon-MM master that fills a RAM word range with
// | pattern+i or reads it back counting mismatches.  Revision 1.0
// +----------------------------------------------------------------------------
module onchip_mem_seq_master
  import onchip_mem_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic            clk,
  input  logic            reset,
  onchip_mem_seq_if.master bus
);

  localparam logic [3:0]      MAX_PEND = 4'(MAX_PENDING);
  localparam logic [3:0]      PEND_ONE = 4'd1;
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ERR_SAT  = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_first_addr_q, err_first_addr_d;

  logic              cmd_ready, accept;
  logic              write_en, read_en, wr_beat, rd_beat, rsp, iss_last;
  logic [ADDR_W:0]   iss_idx, rsp_idx;
  logic [ADDR_W-1:0] iss_addr, rsp_addr;
  logic [DATA_W-1:0] iss_data, rsp_data;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = bus.cmd_valid && cmd_ready;
  // Bus strobes are gated by reset so they fall in the cycle reset is seen.
  assign write_en  = (state_q == ST_WRITE) && !reset;
  assign read_en   = (state_q == ST_READ) && (pending_q < MAX_PEND) && !reset;
  assign wr_beat   = write_en && !bus.avm_waitrequest;
  assign rd_beat   = read_en && !bus.avm_waitrequest;
  assign rsp       = bus.avm_readdatavalid && (pending_q != '0);
  assign iss_last  = (iss_idx == (len_q - LEN_ONE));

  onchip_mem_seq_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_issue (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .adv        (wr_beat || rd_beat),
    .base_in    (bus.cmd_base),
    .pattern_in (bus.cmd_pattern),
    .idx        (iss_idx),
    .addr       (iss_addr),
    .data       (iss_data)
  );

  onchip_mem_seq_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_resp (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .adv        (rsp),
    .base_in    (bus.cmd_base),
    .pattern_in (bus.cmd_pattern),
    .idx        (rsp_idx),
    .addr       (rsp_addr),
    .data       (rsp_data)
  );

  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    len_d            = len_q;
    err_count_d      = err_count_q;
    err_first_addr_d = err_first_addr_q;

    case ({rd_beat, rsp})
      2'b10:   pending_d = pending_q + PEND_ONE;
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase

    if (rsp && (bus.avm_readdata != rsp_data)) begin
      if (err_count_q != ERR_SAT) err_count_d = err_count_q + LEN_ONE;
      if (err_count_q == '0)      err_first_addr_d = rsp_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d            = bus.cmd_len;
          err_count_d      = '0;
          err_first_addr_d = '0;
          if (bus.cmd_len == '0)            state_d = ST_DONE;
          else if (bus.cmd_op == OP_VERIFY) state_d = ST_READ;
          else                              state_d = ST_WRITE;
        end
      end
      ST_WRITE: if (wr_beat && iss_last) state_d = ST_DONE;
      ST_READ:  if (rd_beat && iss_last) state_d = ST_DRAIN;
      ST_DRAIN: if ((pending_q == '0) && (rsp_idx == len_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      pending_q        <= '0;
      len_q            <= '0;
      err_count_q      <= '0;
      err_first_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      len_q            <= len_d;
      err_count_q      <= err_count_d;
      err_first_addr_q <= err_first_addr_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready;
  assign bus.busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.err_count      = err_count_q;
  assign bus.err_first_addr = err_first_addr_q;
  assign bus.avm_address    = iss_addr;
  assign bus.avm_byteenable = '1;
  assign bus.avm_read       = read_en;
  assign bus.avm_write      = write_en;
  assign bus.avm_writedata  = iss_data;

endmodule : onchip_mem_seq_master
`default_nettype wire

// File: tb/tb_onchip_mem_seq_master.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_onchip_mem_seq_master : directed bench with RAM slave model and
// | transaction-level expectation queues.  Revision 1.0
// +----------------------------------------------------------------------------
module tb_onchip_mem_seq_master;
  import onchip_mem_seq_pkg::*;

  localparam int MAXP = 4;

  typedef struct { logic [14:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [14:0] a; int due; logic bad; } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onchip_mem_seq_if bus ();
  onchip_mem_seq_master dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0]  mem [0:32767];
  wr_t          exp_wr[$];
  logic [14:0]  exp_rd[$];
  rsp_t         rsp_q[$];
  int n_cmp = 0, n_err = 0;
  int rd_lat = 1, stall_beat = -1, stall_left = 0, sl_wr = 0, scyc = 0;
  int out_cnt = 0, max_out = 0, wr_beats = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM slave: 1 word per cycle, configurable read latency, optional write stall.
  initial begin
    rsp_t r;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      scyc++;
      bus.avm_readdatavalid = 1'b0;
      if (rsp_q.size() != 0 && rsp_q[0].due <= scyc) begin
        r = rsp_q.pop_front();
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = r.bad ? ~mem[r.a] : mem[r.a];
      end
      bus.avm_waitrequest = 1'b0;
      if (bus.avm_write && sl_wr == stall_beat && stall_left > 0) begin
        bus.avm_waitrequest = 1'b1;
        stall_left--;
      end else if (bus.avm_write) begin
        mem[bus.avm_address] = bus.avm_writedata;
        sl_wr++;
      end
      if (bus.avm_read) rsp_q.push_back('{bus.avm_address, scyc + rd_lat, 1'b0});
    end
  end

  // Per-cycle compare of bus activity against the expectation queues.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        chk("strobes_in_reset", {bus.avm_read, bus.avm_write}, 0);
        out_cnt = 0;
      end else begin
        if (bus.avm_write) begin
          chk("write_expected", exp_wr.size() != 0, 1);
          chk("byteenable", bus.avm_byteenable, 4'hF);
          if (exp_wr.size() != 0) begin
            chk("wr_addr", bus.avm_address, exp_wr[0].a);
            chk("wr_data", bus.avm_writedata, exp_wr[0].d);
            if (!bus.avm_waitrequest) begin
              void'(exp_wr.pop_front());
              wr_beats++;
            end
          end
        end
        if (bus.avm_read) begin
          chk("read_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) begin
            chk("rd_addr", bus.avm_address, exp_rd[0]);
            if (!bus.avm_waitrequest) begin
              void'(exp_rd.pop_front());
              out_cnt++;
              if (out_cnt > max_out) max_out = out_cnt;
              chk("pending_limit", out_cnt <= MAXP, 1);
            end
          end
        end
        if (bus.avm_readdatavalid && out_cnt > 0) out_cnt--;
        if (bus.done) begin
          done_cnt++;
          chk("done_all_beats", exp_wr.size() + exp_rd.size() + out_cnt, 0);
          chk("done_not_busy", bus.busy, 0);
        end
      end
    end
  end

  task automatic run_cmd(input logic op, input logic [14:0] base, input logic [15:0] len,
                         input logic [31:0] pat, output int cyc);
    int errs, d0;
    logic [14:0] first, a;
    logic [31:0] v;
    errs = 0; first = '0; wr_beats = 0; sl_wr = 0; d0 = done_cnt;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 15'(i);
      v = pat + 32'(i);
      if (op == OP_FILL) exp_wr.push_back('{a, v});
      else begin
        exp_rd.push_back(a);
        if (mem[a] !== v) begin
          if (errs == 0) first = a;
          errs++;
        end
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_base = base;
    bus.cmd_len = len; bus.cmd_pattern = pat;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      if (k == 50) begin
        $display("FAIL accept_timeout: got no cmd_ready, required 1");
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    for (int k = 0; k <= 3000; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && len != 0) begin
        chk("busy_after_accept", bus.busy, 1);
        chk("not_ready_while_busy", bus.cmd_ready, 0);
      end
      if (bus.done) break;
      if (k == 3000) begin
        $display("FAIL done_timeout: got no done, required done");
        $fatal(1);
      end
    end
    #3;
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("ready_after_done", bus.cmd_ready, 1);
    chk("done_one_cycle", bus.done, 0);
    chk("write_beats", wr_beats, (op == OP_FILL) ? int'(len) : 0);
    chk("err_count_model", bus.err_count, errs);
    if (errs != 0) chk("err_first_model", bus.err_first_addr, first);
  endtask

  initial begin
    int cyc;
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0;
    bus.cmd_len = '0; bus.cmd_pattern = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_err_first", bus.err_first_addr, 0);
    chk("rst_addr", bus.avm_address, 0);
    chk("rst_wdata", bus.avm_writedata, 0);

    run_cmd(OP_FILL, 15'h010, 16'd4, 32'hA5A5_0000, cyc);
    chk("fill_latency", cyc, 5);
    chk("fill_mem10", mem[15'h010], 32'hA5A5_0000);
    chk("fill_mem13", mem[15'h013], 32'hA5A5_0003);

    run_cmd(OP_VERIFY, 15'h010, 16'd4, 32'hA5A5_0000, cyc);
    chk("verify_clean_errs", bus.err_count, 0);

    mem[15'h012] = '0;
    run_cmd(OP_VERIFY, 15'h010, 16'd4, 32'hA5A5_0000, cyc);
    chk("verify_bad_errs", bus.err_count, 1);
    chk("verify_bad_first", bus.err_first_addr, 15'h012);

    stall_beat = 1; stall_left = 3;
    run_cmd(OP_FILL, 15'h020, 16'd4, 32'h1111_1111, cyc);
    stall_beat = -1;
    chk("stall_latency", cyc, 8);
    chk("stall_mem21", mem[15'h021], 32'h1111_1112);

    run_cmd(OP_FILL, 15'h7FFE, 16'd4, 32'hFFFF_FFFE, cyc);
    chk("wrap_mem7fff", mem[15'h7FFF], 32'hFFFF_FFFF);
    chk("wrap_mem0000", mem[15'h0000], 32'h0000_0000);
    chk("wrap_mem0001", mem[15'h0001], 32'h0000_0001);

    run_cmd(OP_FILL, 15'h100, 16'd0, 32'h5, cyc);
    chk("len0_fill_latency", cyc, 1);
    run_cmd(OP_VERIFY, 15'h100, 16'd0, 32'h5, cyc);
    chk("len0_verify_latency", cyc, 1);

    mem[15'h7FFF] = 32'h1234_5678;
    mem[15'h0001] = 32'h0;
    run_cmd(OP_VERIFY, 15'h7FFE, 16'd4, 32'hFFFF_FFFE, cyc);
    chk("wrap_verify_errs", bus.err_count, 2);
    chk("wrap_verify_first", bus.err_first_addr, 15'h7FFF);

    rd_lat = 6; max_out = 0;
    run_cmd(OP_VERIFY, 15'h010, 16'd8, 32'hA5A5_0000, cyc);
    chk("deep_verify_errs", bus.err_count, 5);
    chk("deep_max_pending", max_out, MAXP);

    // Reset with two reads outstanding; their responses arrive after reset.
    rd_lat = 8;
    for (int i = 0; i < 8; i++) exp_rd.push_back(15'h020 + 15'(i));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_VERIFY; bus.cmd_base = 15'h020;
    bus.cmd_len = 16'd8; bus.cmd_pattern = 32'h1111_1111;
    @(negedge clk);
    chk("rst_test_ready", bus.cmd_ready, 1);
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_test_pending", out_cnt, 2);
    reset = 1'b1;
    exp_rd.delete();
    foreach (rsp_q[i]) rsp_q[i].bad = 1'b1;
    @(negedge clk);
    chk("rst_read_drop", bus.avm_read, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy_low", bus.busy, 0);
    chk("rst_read_low", bus.avm_read, 0);
    chk("rst_ready_high", bus.cmd_ready, 1);
    for (int k = 0; k < 40 && rsp_q.size() != 0; k++) @(negedge clk);
    chk("stray_drained", rsp_q.size(), 0);
    @(negedge clk);
    chk("stray_err_count", bus.err_count, 0);
    chk("stray_busy", bus.busy, 0);

    rd_lat = 1;
    run_cmd(OP_VERIFY, 15'h010, 16'd4, 32'hA5A5_0000, cyc);
    chk("post_rst_errs", bus.err_count, 1);
    chk("post_rst_first", bus.err_first_addr, 15'h012);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_onchip_mem_seq_master
`default_nettype wire
